// File: rtl/mips_reg_dumper_pkg.sv
// Shared definitions for the MIPS register-file dumper: widths, FSM states and a range helper.
// Optional checksum beat is enabled by MIPS_REG_DUMP_CHECKSUM_EN (see mips_reg_dumper.sv).
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dumper_state_e;

    // Number of register beats in an inclusive index range that may wrap past the top index.
    function automatic logic [REG_ADDR_W:0] beat_count(
        input logic [REG_ADDR_W-1:0] first_reg,
        input logic [REG_ADDR_W-1:0] last_reg
    );
        logic [REG_ADDR_W-1:0] span;
        span = last_reg - first_reg;
        return {1'b0, span} + {{REG_ADDR_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mips_reg_dumper_if.sv
// Control, register-file read port and output stream of the register dumper.
// master = dumper side, slave = core / trace sink side.
interface mips_reg_dumper_if
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] read_reg;
    logic [DATA_W-1:0] read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              stall_req;
    logic              done;

    modport master (
        input  start, first_reg, last_reg, read_data, out_ready,
        output read_reg, out_valid, out_data, out_index, out_last, busy, stall_req, done
    );

    modport slave (
        output start, first_reg, last_reg, read_data, out_ready,
        input  read_reg, out_valid, out_data, out_index, out_last, busy, stall_req, done
    );

endinterface

// File: rtl/mips_reg_dumper.sv
// Walks a register index range through one read port and streams each word out on valid/ready.
// Define MIPS_REG_DUMP_CHECKSUM_EN to append a wrapping-sum beat after the register beats.
module mips_reg_dumper
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_reg_dumper_if.master  bus
);

    dumper_state_e     state_q,     state_d;
    logic [ADDR_W-1:0] cur_q,       cur_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q,  out_last_d;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,       sum_d;
    logic              csum_q,      csum_d;
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
        sum_d       = sum_q;
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_d   = bus.first_reg;
                    last_d  = bus.last_reg;
                    state_d = READ;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                    sum_d   = '0;
                    csum_d  = 1'b0;
`endif
                end
            end
            READ: begin
                out_data_d  = bus.read_data;
                out_index_d = cur_q;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = (cur_q == last_q);
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                    if (csum_q) begin
                        state_d = DONE;
                    end else begin
                        sum_d = sum_q + out_data_q;
                        // cur still names the beat being accepted, so this spots the final register
                        if (cur_q == last_q) begin
                            out_data_d  = sum_q + out_data_q;
                            out_index_d = '0;
                            out_last_d  = 1'b1;
                            csum_d      = 1'b1;
                        end else begin
                            cur_d   = cur_q + ADDR_W'(1);
                            state_d = READ;
                        end
                    end
`else
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = READ;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
            sum_q       <= '0;
            csum_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.read_reg  = (state_q == READ || state_q == SEND) ? cur_q : '0;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.stall_req = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule
